// File: rtl/laplace_pkg.sv
// rtl/laplace_pkg.sv - pixel and window types shared by the window generator and the Laplace kernel
package laplace_pkg;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  typedef logic [DEF_PIX_W-1:0] pixel_t;

  // Cross-shaped neighbourhood: north, west, centre, east, south.
  typedef struct packed {
    pixel_t b;
    pixel_t d;
    pixel_t e;
    pixel_t f;
    pixel_t h;
  } window_t;
endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image line of storage, asynchronous read, read-before-write
module line_buffer
  import laplace_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_PIX_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never cleared; rows 0 and 1 of every frame refill them.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/laplace_window_gen.sv
// rtl/laplace_window_gen.sv - raster stream to 5-point cross neighbourhood for the Laplace kernel
module laplace_window_gen
  import laplace_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_b,
  output logic [PIX_W-1:0] out_d,
  output logic [PIX_W-1:0] out_e,
  output logic [PIX_W-1:0] out_f,
  output logic [PIX_W-1:0] out_h,
  output logic             out_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          accept;
  logic          emit;
  logic          last_pix;

  logic [PIX_W-1:0] lb0_rdata;
  logic [PIX_W-1:0] lb1_rdata;

  // Column history; the line-buffer reads and in_pixel are the live third column.
  logic [PIX_W-1:0]      top_q;
  logic [1:0][PIX_W-1:0] mid_q;
  logic [PIX_W-1:0]      bot_q;

  always_comb begin
    accept   = in_valid && !rst;
    cur_col  = in_sof ? '0 : col_cnt;
    cur_row  = in_sof ? '0 : row_cnt;
    emit     = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  end

  line_buffer #(
    .DEPTH(IMG_W),
    .WIDTH(PIX_W)
  ) u_lb0 (
    .clk  (clk),
    .we   (accept),
    .addr (cur_col),
    .wdata(in_pixel),
    .rdata(lb0_rdata)
  );

  line_buffer #(
    .DEPTH(IMG_W),
    .WIDTH(PIX_W)
  ) u_lb1 (
    .clk  (clk),
    .we   (accept),
    .addr (cur_col),
    .wdata(lb0_rdata),
    .rdata(lb1_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      top_q     <= '0;
      mid_q     <= '0;
      bot_q     <= '0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_b     <= '0;
      out_d     <= '0;
      out_e     <= '0;
      out_f     <= '0;
      out_h     <= '0;
    end else begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      if (accept) begin
        if (cur_col == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
        end else begin
          col_cnt <= cur_col + 1'b1;
          row_cnt <= cur_row;
        end
        top_q <= lb1_rdata;
        mid_q <= {mid_q[0], lb0_rdata};
        bot_q <= in_pixel;
        // Centre is (r-1, c-1) relative to the pixel being accepted.
        if (emit) begin
          out_valid <= 1'b1;
          out_eof   <= last_pix;
          out_b     <= top_q;
          out_d     <= mid_q[1];
          out_e     <= mid_q[0];
          out_f     <= lb0_rdata;
          out_h     <= bot_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_laplace_window_gen.sv
// tb/tb_laplace_window_gen.sv - scoreboard bench for laplace_window_gen (4x4 and 5x3 instances)
module tb_laplace_window_gen;

  typedef struct {
    logic [7:0] b;
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] f;
    logic [7:0] h;
    logic       eof;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid_s [2];
  logic       in_sof_s   [2];
  logic [7:0] in_pixel_s [2];
  logic       ov   [2];
  logic       oeof [2];
  logic [7:0] ob [2];
  logic [7:0] od [2];
  logic [7:0] oe [2];
  logic [7:0] of_ [2];
  logic [7:0] oh [2];

  laplace_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[0]), .in_sof(in_sof_s[0]), .in_pixel(in_pixel_s[0]),
    .out_valid(ov[0]), .out_b(ob[0]), .out_d(od[0]), .out_e(oe[0]),
    .out_f(of_[0]), .out_h(oh[0]), .out_eof(oeof[0])
  );

  laplace_window_gen #(.IMG_W(5), .IMG_H(3), .PIX_W(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[1]), .in_sof(in_sof_s[1]), .in_pixel(in_pixel_s[1]),
    .out_valid(ov[1]), .out_b(ob[1]), .out_d(od[1]), .out_e(oe[1]),
    .out_f(of_[1]), .out_h(oh[1]), .out_eof(oeof[1])
  );

  int img_w [2] = '{4, 5};
  int img_h [2] = '{4, 3};
  int pr [2];
  int pc [2];
  logic [7:0] img [2][8][8];
  win_t q0 [$];
  win_t q1 [$];
  logic pend_v [2];
  logic exp_q  [2];
  logic mon_en = 1'b0;
  int   win_cnt [2];
  int   eof_cnt [2];
  logic first_cap = 1'b0;
  win_t first_w;
  win_t mw;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    exp_q[0] <= pend_v[0];
    exp_q[1] <= pend_v[1];
  end

  // Monitor: timing of out_valid plus in-order window comparison against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("valid_timing%0d", i), 32'(ov[i]), 32'(exp_q[i]));
        if (ov[i] === 1'b1) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            check($sformatf("unexpected_window%0d", i), 32'(1), 32'(0));
          end else begin
            mw = (i == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("b%0d", i), 32'(ob[i]), 32'(mw.b));
            check($sformatf("d%0d", i), 32'(od[i]), 32'(mw.d));
            check($sformatf("e%0d", i), 32'(oe[i]), 32'(mw.e));
            check($sformatf("f%0d", i), 32'(of_[i]), 32'(mw.f));
            check($sformatf("h%0d", i), 32'(oh[i]), 32'(mw.h));
            check($sformatf("eof%0d", i), 32'(oeof[i]), 32'(mw.eof));
          end
          if (i == 0 && first_cap) begin
            first_w.b = ob[0]; first_w.d = od[0]; first_w.e = oe[0];
            first_w.f = of_[0]; first_w.h = oh[0]; first_w.eof = oeof[0];
            first_cap = 1'b0;
          end
          win_cnt[i]++;
          if (oeof[i] === 1'b1) eof_cnt[i]++;
        end else begin
          check($sformatf("eof_idle%0d", i), 32'(oeof[i]), 32'(0));
        end
      end
    end
  end

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      in_valid_s[i] = 1'b0;
      in_sof_s[i]   = 1'b0;
      in_pixel_s[i] = 8'h00;
      pend_v[i]     = 1'b0;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // Reference: position tracked in raster terms, windows read from a 2-D image copy.
  task automatic send(input int i, input logic [7:0] p, input logic sof);
    int r, c;
    win_t w;
    @(posedge clk); #1;
    clear_inputs();
    in_valid_s[i] = 1'b1;
    in_sof_s[i]   = sof;
    in_pixel_s[i] = p;
    if (sof) begin
      pr[i] = 0;
      pc[i] = 0;
    end
    r = pr[i];
    c = pc[i];
    img[i][r][c] = p;
    if (r >= 2 && c >= 2) begin
      pend_v[i] = 1'b1;
      w.b = img[i][r-2][c-1];
      w.d = img[i][r-1][c-2];
      w.e = img[i][r-1][c-1];
      w.f = img[i][r-1][c];
      w.h = img[i][r][c-1];
      w.eof = (r == img_h[i] - 1) && (c == img_w[i] - 1);
      if (i == 0) q0.push_back(w);
      else q1.push_back(w);
    end
    c++;
    if (c == img_w[i]) begin
      c = 0;
      r++;
      if (r == img_h[i]) r = 0;
    end
    pr[i] = r;
    pc[i] = c;
  endtask

  function automatic logic [7:0] pixval(int mode, int r, int c, int off);
    case (mode)
      0: return 8'(16 * r + c + off);
      1: return 8'($urandom);
      2: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic send_rows(input int i, input int mode, input int off, input int nr, input int nc_last);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < img_w[i]; c++)
        if (r < nr - 1 || c < nc_last)
          send(i, pixval(mode, r, c, off), 1'b0);
  endtask

  task automatic send_frame(input int i, input int mode, input int off, input logic sof, input logic gaps);
    for (int r = 0; r < img_h[i]; r++)
      for (int c = 0; c < img_w[i]; c++) begin
        if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) idle();
        send(i, pixval(mode, r, c, off), sof && r == 0 && c == 0);
      end
  endtask

  task automatic finish_test(input int i, input int exp_win, input int exp_eof, input string name);
    repeat (3) idle();
    check({name, "_queue_drained"}, 32'(i == 0 ? q0.size() : q1.size()), 32'(0));
    check({name, "_windows"}, 32'(win_cnt[i]), 32'(exp_win));
    check({name, "_eofs"}, 32'(eof_cnt[i]), 32'(exp_eof));
    win_cnt[i] = 0;
    eof_cnt[i] = 0;
  endtask

  task automatic check_zero(input int i, input string name);
    check({name, "_valid"}, 32'(ov[i]), 32'(0));
    check({name, "_eof"}, 32'(oeof[i]), 32'(0));
    check({name, "_b"}, 32'(ob[i]), 32'(0));
    check({name, "_d"}, 32'(od[i]), 32'(0));
    check({name, "_e"}, 32'(oe[i]), 32'(0));
    check({name, "_f"}, 32'(of_[i]), 32'(0));
    check({name, "_h"}, 32'(oh[i]), 32'(0));
  endtask

  // Reset for one cycle while instance 0 presents a pixel with sof, which must be ignored.
  task automatic pulse_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b1;
    in_valid_s[0] = 1'b1;
    in_sof_s[0]   = 1'b1;
    in_pixel_s[0] = 8'hAA;
    for (int i = 0; i < 2; i++) begin
      pr[i] = 0;
      pc[i] = 0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      pr[i] = 0; pc[i] = 0; win_cnt[i] = 0; eof_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero(0, "reset_a");
    check_zero(1, "reset_b");
    mon_en = 1'b1;

    first_cap = 1'b1;
    send_frame(0, 0, 0, 1'b1, 1'b0);
    finish_test(0, 4, 1, "basic");
    check("first_b", 32'(first_w.b), 32'd1);
    check("first_d", 32'(first_w.d), 32'd16);
    check("first_e", 32'(first_w.e), 32'd17);
    check("first_f", 32'(first_w.f), 32'd18);
    check("first_h", 32'(first_w.h), 32'd33);

    send_frame(0, 0, 0, 1'b1, 1'b1);
    finish_test(0, 4, 1, "bubbles");
    send_frame(0, 1, 0, 1'b0, 1'b1);
    finish_test(0, 4, 1, "random_gaps");

    send_frame(1, 0, 0, 1'b1, 1'b0);
    send_frame(1, 0, 128, 1'b0, 1'b0);
    finish_test(1, 6, 2, "back_to_back");
    send_frame(1, 1, 0, 1'b0, 1'b1);
    finish_test(1, 3, 1, "b_random");

    send_rows(0, 1, 0, 2, 2);
    send_frame(0, 1, 0, 1'b1, 1'b0);
    finish_test(0, 4, 1, "resync");

    send_rows(0, 0, 64, 3, 1);
    pulse_reset();
    check_zero(0, "midreset_a");
    send_frame(0, 0, 0, 1'b0, 1'b0);
    finish_test(0, 4, 1, "after_reset");

    send_frame(0, 2, 0, 1'b1, 1'b0);
    finish_test(0, 4, 1, "all_ff");
    send_frame(0, 3, 0, 1'b1, 1'b0);
    finish_test(0, 4, 1, "all_zero");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
